// File: rtl/ascii_number_parser.sv
// Parses an optionally signed decimal token from a byte stream into a saturated
// two's-complement value and reports the terminating character alongside it.
module ascii_number_parser #(
  parameter int unsigned NUM_BITS = 16,
  localparam int unsigned BYTE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BYTE_BITS-1:0] char_in,
  input  logic                 char_valid,
  output logic                 char_ready,
  output logic [NUM_BITS-1:0]  num_out,
  output logic                 num_valid,
  input  logic                 num_ready,
  output logic [BYTE_BITS-1:0] term_char_out,
  output logic                 overflow_out,
  output logic                 empty_out
);

  localparam int unsigned EXT_BITS = NUM_BITS + 4;
  localparam logic [EXT_BITS-1:0] MAX_EXT =
    (EXT_BITS'(1) << (NUM_BITS - 1)) - EXT_BITS'(1);
  localparam logic [NUM_BITS-1:0] MAX_MAG = NUM_BITS'(MAX_EXT);

  localparam logic [BYTE_BITS-1:0] CH_MINUS = 8'h2D;
  localparam logic [BYTE_BITS-1:0] CH_PLUS  = 8'h2B;
  localparam logic [BYTE_BITS-1:0] CH_ZERO  = 8'h30;
  localparam logic [BYTE_BITS-1:0] CH_NINE  = 8'h39;

  typedef enum logic [1:0] {IDLE, SIGN, DIGITS, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_BITS-1:0]   r_mag, w_mag_nxt;
  logic                  r_neg, w_neg_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_empty, w_empty_nxt;
  logic [BYTE_BITS-1:0]  r_term, w_term_nxt;
  logic [NUM_BITS-1:0]   r_num, w_num_nxt;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_is_digit;
  logic [3:0]            w_digit;
  logic [EXT_BITS-1:0]   w_acc_ext;
  logic [NUM_BITS-1:0]   w_signed;

  assign char_ready = (r_state != DONE);
  assign w_accept   = char_valid && char_ready;
  assign w_is_digit = (char_in >= CH_ZERO) && (char_in <= CH_NINE);
  assign w_digit    = char_in[3:0];

  // Wide accumulate so the saturation test sees the true result.
  assign w_acc_ext  = (EXT_BITS'(r_mag) * EXT_BITS'(10)) + EXT_BITS'(w_digit);
  assign w_signed   = r_neg ? (NUM_BITS'(0) - r_mag) : r_mag;

  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_neg_nxt   = r_neg;
    w_ovf_nxt   = r_ovf;
    w_empty_nxt = r_empty;
    w_term_nxt  = r_term;
    w_num_nxt   = r_num;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (char_in == CH_MINUS) begin
            w_state_nxt = SIGN;
            w_neg_nxt   = 1'b1;
          end else if (char_in == CH_PLUS) begin
            w_state_nxt = SIGN;
            w_neg_nxt   = 1'b0;
          end else if (w_is_digit) begin
            w_state_nxt = DIGITS;
            w_mag_nxt   = NUM_BITS'(w_digit);
          end else begin
            w_state_nxt = DONE;
            w_empty_nxt = 1'b1;
            w_term_nxt  = char_in;
            w_num_nxt   = '0;
          end
        end
      end
      SIGN: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_state_nxt = DIGITS;
            w_mag_nxt   = NUM_BITS'(w_digit);
          end else begin
            // A bare sign yields an empty token with value zero.
            w_state_nxt = DONE;
            w_empty_nxt = 1'b1;
            w_term_nxt  = char_in;
            w_num_nxt   = '0;
            w_neg_nxt   = 1'b0;
          end
        end
      end
      DIGITS: begin
        if (w_accept) begin
          if (w_is_digit) begin
            if (w_acc_ext > MAX_EXT) begin
              w_mag_nxt = MAX_MAG;
              w_ovf_nxt = 1'b1;
            end else begin
              w_mag_nxt = NUM_BITS'(w_acc_ext);
            end
          end else begin
            w_state_nxt = DONE;
            w_term_nxt  = char_in;
            w_num_nxt   = w_signed;
          end
        end
      end
      DONE: begin
        if (num_ready) begin
          w_state_nxt = IDLE;
          w_mag_nxt   = '0;
          w_neg_nxt   = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_empty_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_empty <= 1'b0;
      r_term  <= '0;
      r_num   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mag   <= w_mag_nxt;
      r_neg   <= w_neg_nxt;
      r_ovf   <= w_ovf_nxt;
      r_empty <= w_empty_nxt;
      r_term  <= w_term_nxt;
      r_num   <= w_num_nxt;
      r_valid <= (w_state_nxt == DONE);
    end
  end

  assign num_out       = r_num;
  assign num_valid     = r_valid;
  assign term_char_out = r_term;
  assign overflow_out  = r_ovf;
  assign empty_out     = r_empty;

endmodule

// File: tb/tb_ascii_number_parser.sv
// Scoreboard bench for ascii_number_parser: directed tokens plus random tokens
// scored against a token-level reference model.
module tb_ascii_number_parser;

  localparam int unsigned NB = 16;
  localparam longint MAXV = (longint'(1) << (NB - 1)) - 1;

  typedef logic [7:0] tok_t [$];
  typedef struct {
    logic [NB-1:0] num;
    logic [7:0]    term;
    logic          ovf;
    logic          empty;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic [NB-1:0] num_out;
  logic          num_valid;
  logic          num_ready;
  logic [7:0]    term_char_out;
  logic          overflow_out;
  logic          empty_out;

  ascii_number_parser #(.NUM_BITS(NB)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .num_out(num_out), .num_valid(num_valid),
    .num_ready(num_ready), .term_char_out(term_char_out),
    .overflow_out(overflow_out), .empty_out(empty_out));

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_mode = 2;   // 0 random, 1 held low, 2 held high
  exp_t exp_q[$];
  int   acc_q[$];
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [NB-1:0] n, input logic [7:0] t,
                              input logic o, input logic e);
    exp_t r;
    r.num = n; r.term = t; r.ovf = o; r.empty = e;
    return r;
  endfunction

  function automatic tok_t s2t(input string s);
    tok_t t;
    for (int i = 0; i < s.len(); i++) t.push_back(s[i]);
    return t;
  endfunction

  // Token-level model: optional sign, digit run clamped at MAXV, terminator.
  function automatic exp_t model(input tok_t t);
    exp_t   e;
    int     i = 0;
    int     nd = 0;
    bit     neg = 1'b0;
    bit     sat = 1'b0;
    longint v = 0;
    if (t[0] == 8'h2D || t[0] == 8'h2B) begin
      neg = (t[0] == 8'h2D);
      i = 1;
    end
    while (t[i] >= 8'h30 && t[i] <= 8'h39) begin
      v = v * 10 + longint'(t[i] - 8'h30);
      if (v > MAXV) begin
        v = MAXV;
        sat = 1'b1;
      end
      nd++;
      i++;
    end
    e.term  = t[i];
    e.empty = (nd == 0);
    e.ovf   = sat;
    e.num   = (neg && nd > 0) ? NB'(-v) : NB'(v);
    return e;
  endfunction

  function automatic tok_t gen_tok();
    tok_t t;
    logic [7:0] terms [9] = '{8'h20, 8'h0A, 8'h3B, 8'h2C, 8'h58, 8'h47, 8'h2D, 8'h2B, 8'h2E};
    int s  = $urandom_range(0, 2);
    int nd = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 5);
    if (s == 1) t.push_back(8'h2D);
    if (s == 2) t.push_back(8'h2B);
    for (int i = 0; i < nd; i++) t.push_back(8'(8'h30 + $urandom_range(0, 9)));
    if (s == 0 && nd == 0) t.push_back(terms[$urandom_range(0, 5)]);
    else                   t.push_back(terms[$urandom_range(0, 8)]);
    return t;
  endfunction

  task automatic send_char(input logic [7:0] b, input bit is_term, input int gap);
    int n = 0;
    repeat (gap) begin
      char_valid = 1'b0;
      char_in    = 8'($urandom);
      @(posedge clk); #1;
    end
    char_valid = 1'b1;
    char_in    = b;
    forever begin
      @(negedge clk);
      if (char_ready) break;
      n++;
      if (n > 300) begin
        chk("char_ready_timeout", 32'(char_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    if (is_term) acc_q.push_back(cyc);
    char_valid = 1'b0;
    char_in    = 8'($urandom);
  endtask

  task automatic send_tok(input tok_t t, input exp_t e, input bit gaps);
    exp_q.push_back(e);
    for (int i = 0; i < t.size(); i++)
      send_char(t[i], i == t.size() - 1, gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      num_ready = (ready_mode == 1) ? 1'b0 :
                  (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every valid cycle must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      chk("ready_vs_valid", 32'(char_ready), 32'(!num_valid));
      if (num_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("latency_no_term", 32'd1, 32'd0);
        else chk("latency", 32'(cyc), 32'(acc_q.pop_front()));
      end
      if (num_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(num_out), 32'hFFFF_FFFF);
        end else begin
          chk("num_out", 32'(num_out), 32'(exp_q[0].num));
          chk("term_char", 32'(term_char_out), 32'(exp_q[0].term));
          chk("overflow", 32'(overflow_out), 32'(exp_q[0].ovf));
          chk("empty", 32'(empty_out), 32'(exp_q[0].empty));
          if (num_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = num_valid;
    end
  end

  initial begin
    int w;
    reset      = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    num_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_num", 32'(num_out), 32'd0);
    chk("rst_valid", 32'(num_valid), 32'd0);
    chk("rst_term", 32'(term_char_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_empty", 32'(empty_out), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    // Idle garbage with char_valid low must not start a token.
    repeat (5) begin
      char_in = 8'($urandom);
      @(posedge clk); #1;
    end

    ready_mode = 2;
    send_tok(s2t("123 "),    mk(16'd123,  8'h20, 1'b0, 1'b0), 1'b0);
    send_tok(s2t("-45\n"),   mk(16'hFFD3, 8'h0A, 1'b0, 1'b0), 1'b0);
    send_tok(s2t("40000;"),  mk(16'd32767, 8'h3B, 1'b1, 1'b0), 1'b0);
    send_tok(s2t("-99999;"), mk(16'h8001, 8'h3B, 1'b1, 1'b0), 1'b0);
    send_tok(s2t("-X"),      mk(16'd0,    8'h58, 1'b0, 1'b1), 1'b0);
    send_tok(s2t("X"),       mk(16'd0,    8'h58, 1'b0, 1'b1), 1'b0);
    send_tok(s2t("007 "),    mk(16'd7,    8'h20, 1'b0, 1'b0), 1'b0);
    send_tok(s2t("-0,"),     mk(16'd0,    8'h2C, 1'b0, 1'b0), 1'b0);
    send_tok(s2t("+32767 "), mk(16'd32767, 8'h20, 1'b0, 1'b0), 1'b0);
    send_tok(s2t("-32768 "), mk(16'h8001, 8'h20, 1'b1, 1'b0), 1'b0);

    // Downstream stall: result must hold, no characters accepted.
    @(posedge clk); #1;
    ready_mode = 1;
    send_tok(s2t("12,"), mk(16'd12, 8'h2C, 1'b0, 1'b0), 1'b0);
    char_valid = 1'b1;
    char_in    = 8'h31;
    repeat (4) begin
      @(negedge clk);
      chk("stall_ready", 32'(char_ready), 32'd0);
      @(posedge clk); #1;
    end
    char_valid = 1'b0;
    ready_mode = 2;
    repeat (2) @(posedge clk); #1;
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-token discards the partial value.
    send_char(8'h31, 1'b0, 0);
    send_char(8'h32, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_num", 32'(num_out), 32'd0);
    chk("midrst_valid", 32'(num_valid), 32'd0);
    chk("midrst_term", 32'(term_char_out), 32'd0);
    chk("midrst_ovf", 32'(overflow_out), 32'd0);
    chk("midrst_empty", 32'(empty_out), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_tok(s2t("7 "), mk(16'd7, 8'h20, 1'b0, 1'b0), 1'b0);

    ready_mode = 0;
    for (int k = 0; k < 200; k++) begin
      tok_t t;
      t = gen_tok();
      send_tok(t, model(t), 1'b1);
    end

    ready_mode = 2;
    w = 0;
    while (exp_q.size() > 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    repeat (5) @(posedge clk);
    chk("drain_exp", 32'(exp_q.size()), 32'd0);
    chk("drain_acc", 32'(acc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
